// File: rtl/cordic_rotate_seq.sv
// Iterative CORDIC rotation engine: one micro-rotation per clock, raw (non gain-compensated)
// result held under a valid/ready handshake until the consumer takes it.
module cordic_rotate_seq #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16,
    parameter int GUARD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] angle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] angle_out,
    output logic             busy
);

    localparam int IW = WIDTH + GUARD;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic signed [IW-1:0]   xr_r;
    logic signed [IW-1:0]   yr_r;
    logic [WIDTH-1:0]       zr_r;
    logic [CW-1:0]          step_r;

    logic signed [IW-1:0]   xs_s;
    logic signed [IW-1:0]   ys_s;
    logic signed [IW-1:0]   x_nxt_s;
    logic signed [IW-1:0]   y_nxt_s;
    logic [WIDTH-1:0]       z_nxt_s;
    logic [WIDTH-1:0]       atan_s;
    logic                   d_pos_s;
    logic                   last_step_s;

    // atan(2^-i) in binary-angle units of a 16-bit angle word (0x4000 = 90 deg)
    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        logic [15:0] v;
        case (idx)
            4'd0:    v = 16'h2000;
            4'd1:    v = 16'h12E4;
            4'd2:    v = 16'h09FB;
            4'd3:    v = 16'h0511;
            4'd4:    v = 16'h028B;
            4'd5:    v = 16'h0146;
            4'd6:    v = 16'h00A3;
            4'd7:    v = 16'h0051;
            4'd8:    v = 16'h0029;
            4'd9:    v = 16'h0014;
            4'd10:   v = 16'h000A;
            4'd11:   v = 16'h0005;
            4'd12:   v = 16'h0003;
            4'd13:   v = 16'h0001;
            4'd14:   v = 16'h0001;
            4'd15:   v = 16'h0000;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // Clamp the guarded datapath value into the signed WIDTH-bit output range
    function automatic logic [WIDTH-1:0] sat_w(input logic signed [IW-1:0] v);
        logic [WIDTH-1:0] r;
        if ((&v[IW-1:WIDTH-1]) || !(|v[IW-1:WIDTH-1])) begin
            r = v[WIDTH-1:0];
        end else if (v[IW-1]) begin
            r = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return r;
    endfunction

    // One micro-rotation; zr == 0 rotates in the positive direction
    always_comb begin
        d_pos_s     = ~zr_r[WIDTH-1];
        xs_s        = xr_r >>> step_r;
        ys_s        = yr_r >>> step_r;
        atan_s      = WIDTH'(atan_lut(4'(step_r)));
        last_step_s = (step_r == CW'(ITER - 1));
        if (d_pos_s) begin
            x_nxt_s = xr_r - ys_s;
            y_nxt_s = yr_r + xs_s;
            z_nxt_s = zr_r - atan_s;
        end else begin
            x_nxt_s = xr_r + ys_s;
            y_nxt_s = yr_r - xs_s;
            z_nxt_s = zr_r + atan_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_step_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake and status decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_r)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Operand capture, iteration registers and held result
    always_ff @(posedge clk) begin
        if (rst) begin
            xr_r      <= '0;
            yr_r      <= '0;
            zr_r      <= '0;
            step_r    <= '0;
            x_out     <= '0;
            y_out     <= '0;
            angle_out <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        xr_r   <= {{GUARD{x[WIDTH-1]}}, x};
                        yr_r   <= {{GUARD{y[WIDTH-1]}}, y};
                        zr_r   <= angle;
                        step_r <= '0;
                    end
                end
                ST_RUN: begin
                    xr_r   <= x_nxt_s;
                    yr_r   <= y_nxt_s;
                    zr_r   <= z_nxt_s;
                    step_r <= step_r + CW'(1);
                    if (last_step_s) begin
                        x_out     <= sat_w(x_nxt_s);
                        y_out     <= sat_w(y_nxt_s);
                        angle_out <= z_nxt_s;
                    end
                end
                default: begin
                    step_r <= step_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rotate_seq.sv
// Scoreboard bench for cordic_rotate_seq: stimulus pushes expected results, a monitor
// pops and compares them on each output handshake.
module tb_cordic_rotate_seq;

    localparam int ITER = 16;
    localparam real PI  = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] angle;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic [15:0] angle_out;
    logic        busy;

    typedef struct {
        int ex;
        int ey;
        int ez;
        int txy;
        int tz;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   atan_tab[16];

    cordic_rotate_seq #(.WIDTH(16), .ITER(ITER), .GUARD(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .angle(angle), .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .angle_out(angle_out), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        int diff;
        diff = act - exp;
        if (diff < 0) diff = -diff;
        n_cmp++;
        if (diff > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    // Reference: the rotation rules applied with plain integer arithmetic
    function automatic exp_t model(input int x0, input int y0, input int a0);
        exp_t e;
        int xr, yr, zr, xn;
        xr = x0; yr = y0; zr = a0;
        for (int i = 0; i < ITER; i++) begin
            if (zr >= 0) begin
                xn = xr - (yr >>> i);
                yr = yr + (xr >>> i);
                zr = zr - atan_tab[i];
            end else begin
                xn = xr + (yr >>> i);
                yr = yr - (xr >>> i);
                zr = zr + atan_tab[i];
            end
            xr = xn;
            zr = s16(16'(zr));
        end
        e.ex  = (xr > 32767) ? 32767 : ((xr < -32768) ? -32768 : xr);
        e.ey  = (yr > 32767) ? 32767 : ((yr < -32768) ? -32768 : yr);
        e.ez  = zr;
        e.txy = 0;
        e.tz  = 0;
        return e;
    endfunction

    task automatic push_model(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] ai);
        sb_q.push_back(model(s16(xi), s16(yi), s16(ai)));
    endtask

    task automatic push_tol(input int ex, input int ey);
        exp_t e;
        e.ex = ex; e.ey = ey; e.ez = 0; e.txy = 4; e.tz = 2;
        sb_q.push_back(e);
    endtask

    // Present one operand set; returns #1 after the accept edge with inputs scrambled
    task automatic accept(input logic [15:0] xi, input logic [15:0] yi, input logic [15:0] ai);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) chk("in_ready_wait", 0, 1, 0);
        x = xi; y = yi; angle = ai; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x = 16'($urandom); y = 16'($urandom); angle = 16'($urandom);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1, 0);
    endtask

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got out_valid=1, expected none pending");
            end else begin
                e = sb_q.pop_front();
                chk("x_out", s16(x_out), e.ex, e.txy);
                chk("y_out", s16(y_out), e.ey, e.txy);
                chk("angle_out", s16(angle_out), e.ez, e.tz);
            end
        end
    end

    initial begin
        int cyc;
        int bad_hold;
        int seen;
        logic [15:0] hx, hy, hz, rx, ry, ra;

        for (int i = 0; i < 16; i++) begin
            atan_tab[i] = $rtoi($atan(1.0 / (2.0 ** i)) * 65536.0 / (2.0 * PI) + 0.5);
        end

        // Reset held three cycles
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = 16'h0000; y = 16'h0000; angle = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x_out", int'(x_out), 0, 0);
        chk("rst_y_out", int'(y_out), 0, 0);
        chk("rst_angle_out", int'(angle_out), 0, 0);
        chk("rst_out_valid", int'(out_valid), 0, 0);
        chk("rst_busy", int'(busy), 0, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", int'(in_ready), 1, 0);

        // Zero angle: gain only, with exact latency
        push_tol(26981, 0);
        accept(16'h4000, 16'h0000, 16'h0000);
        wait_valid(cyc);
        chk("latency", cyc, ITER, 0);
        @(posedge clk); #1;

        // +45 degrees
        push_tol(19079, 19079);
        accept(16'h4000, 16'h0000, 16'h2000);
        wait_valid(cyc);
        @(posedge clk); #1;

        // -90 degrees
        push_tol(0, -26981);
        accept(16'h4000, 16'h0000, 16'hC000);
        wait_valid(cyc);
        @(posedge clk); #1;

        // Back-pressure for 10 cycles with in_valid pulses during RUN and DONE
        out_ready = 1'b0;
        push_model(16'h1234, 16'hE000, 16'h1800);
        accept(16'h1234, 16'hE000, 16'h1800);
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            in_valid = cyc[0];
            x = 16'($urandom); y = 16'($urandom); angle = 16'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        chk("stall_out_valid", int'(out_valid), 1, 0);
        hx = x_out; hy = y_out; hz = angle_out;
        bad_hold = 0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            x = 16'($urandom); y = 16'($urandom); angle = 16'($urandom);
            @(posedge clk); #1;
            if (!out_valid || x_out != hx || y_out != hy || angle_out != hz || in_ready) bad_hold++;
        end
        chk("stall_hold_stable", bad_hold, 0, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_handshake_in_ready", int'(in_ready), 1, 0);

        // Reset at RUN step 7 aborts without a result
        accept(16'h3000, 16'h1000, 16'h0800);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0, 0);
        chk("abort_out_valid", int'(out_valid), 0, 0);
        chk("abort_x_out", int'(x_out), 0, 0);
        chk("abort_y_out", int'(y_out), 0, 0);
        chk("abort_angle_out", int'(angle_out), 0, 0);
        chk("abort_in_ready", int'(in_ready), 1, 0);
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0, 0);
        push_model(16'hC000, 16'h2000, 16'h3A00);
        accept(16'hC000, 16'h2000, 16'h3A00);
        wait_valid(cyc);
        chk("latency_after_abort", cyc, ITER, 0);
        @(posedge clk); #1;

        // Random operands (full-range x/y, angle within +/-90 degrees) with random stalls
        for (int n = 0; n < 30; n++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            ra = 16'($urandom_range(0, 32768) - 16384);
            out_ready = ($urandom_range(0, 2) != 0);
            push_model(rx, ry, ra);
            accept(rx, ry, ra);
            wait_valid(cyc);
            chk("latency_rand", cyc, ITER, 0);
            if (!out_ready) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end

        cyc = 0;
        while (sb_q.size() != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("scoreboard_drained", sb_q.size(), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
